// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serializes I-cache fills and D-cache fills/write-backs onto one
//            fixed-latency main-memory port. Define ARB_RR_EN to replace the
//            fixed D-first tie-break with a round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 14,
    parameter int LW  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_rdy,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [LW-1:0] d_wdata,
    output logic          d_rdy,
    output logic [LW-1:0] rd_line,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [LW-1:0] mem_wdata,
    input  logic [LW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_init = 4'(LAT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_gnt_d;
    logic       w_gnt_d;
    logic       w_gnt_any;

    assign w_gnt_any = i_req | d_req;

`ifdef ARB_RR_EN
    logic r_last_d;

    // On a tie the side that did not win last time takes the grant.
    assign w_gnt_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == S_IDLE && w_gnt_any) begin
            r_last_d <= w_gnt_d;
        end
    end
`else
    assign w_gnt_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_gnt_d   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            rd_line   <= '0;
            i_rdy     <= 1'b0;
            d_rdy     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_gnt_d  <= w_gnt_d;
                        mem_addr <= w_gnt_d ? d_addr : i_addr;
                        mem_re   <= ~(w_gnt_d & d_we);
                        mem_we   <= w_gnt_d & d_we;
                        if (w_gnt_d) begin
                            mem_wdata <= d_wdata;
                        end
                        r_cnt    <= c_cnt_init;
                        busy     <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        // mem_rdata is valid only in the last cycle of the strobe.
                        if (mem_re) begin
                            rd_line <= mem_rdata;
                        end
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                        i_rdy   <= ~r_gnt_d;
                        d_rdy   <= r_gnt_d;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    i_rdy   <= 1'b0;
                    d_rdy   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
